// File: rtl/pdm_pkg.sv
// Shared sizing defaults and LFSR constants for the second-order PDM modulator.
package pdm_pkg;
   localparam int PCM_W   = 12;
   localparam int OSR     = 64;
   localparam int ACC_W   = PCM_W + 4;
   localparam int FS      = 2 ** (PCM_W - 1);
   localparam int ACC_MAX = 2 ** (ACC_W - 1) - 1;
   localparam int ACC_MIN = -(2 ** (ACC_W - 1));

   // Galois right-shift polynomial x^16+x^14+x^13+x^11 (maximal length)
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/pdm_lfsr.sv
// 16-bit maximal LFSR supplying the +/-1 LSB dither select; reloads its seed on reset.
module pdm_lfsr
   import pdm_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic bit_out
);

   logic [15:0] state_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= LFSR_SEED;
      end else if (en) begin
         state_reg <= {1'b0, state_reg[15:1]} ^ (state_reg[0] ? LFSR_TAPS : 16'h0000);
      end
   end

   assign bit_out = state_reg[0];

endmodule

// File: rtl/pdm_modulator.sv
// Second-order sigma-delta PCM-to-PDM modulator with zero-order-hold input.
// Define PDM_DITHER_EN to add LFSR-driven +/-1 LSB dither to the held sample.
module pdm_modulator #(
   parameter int PCM_W = pdm_pkg::PCM_W,
   parameter int OSR   = pdm_pkg::OSR
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [PCM_W-1:0] pcm_data,
   input  logic                    pcm_valid,
   output logic                    pcm_ready,
   output logic                    pdm_out,
   output logic                    underrun,
   input  logic                    underrun_clr
);

   localparam int PH_W  = $clog2(OSR);
   localparam int ACC_W = PCM_W + 4;

   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic signed [ACC_W+1:0] wide_t;

   localparam acc_t FS      = {{(ACC_W-PCM_W){1'b0}}, 1'b1, {(PCM_W-1){1'b0}}};
   localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   function automatic wide_t widen(input acc_t v);
      return {{2{v[ACC_W-1]}}, v};
   endfunction

   function automatic acc_t sat(input wide_t v);
      if (v > widen(ACC_MAX))
         return ACC_MAX;
      else if (v < widen(ACC_MIN))
         return ACC_MIN;
      else
         return v[ACC_W-1:0];
   endfunction

   logic [PH_W-1:0]         phase_reg;
   logic signed [PCM_W-1:0] x_reg;
   acc_t                    i1_reg, i2_reg;
   logic                    pdm_reg, underrun_reg, primed_reg;

   acc_t x_ext, x_eff, fb, i1_next, i2_next;
   logic take;

   assign pcm_ready = (phase_reg == PH_W'(OSR - 1));
   assign take      = pcm_ready & pcm_valid;
   assign x_ext     = {{(ACC_W-PCM_W){x_reg[PCM_W-1]}}, x_reg};
   assign fb        = pdm_reg ? FS : -FS;

`ifdef PDM_DITHER_EN
   logic lfsr_bit;

   pdm_lfsr u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (1'b1),
      .bit_out (lfsr_bit)
   );

   assign x_eff = lfsr_bit ? (x_ext + acc_t'(1)) : (x_ext - acc_t'(1));
`else
   assign x_eff = x_ext;
`endif

   assign i1_next = sat(widen(i1_reg) + widen(x_eff) - widen(fb));
   assign i2_next = sat(widen(i2_reg) + widen(i1_reg) - widen(fb));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_reg    <= '0;
         x_reg        <= '0;
         i1_reg       <= '0;
         i2_reg       <= '0;
         pdm_reg      <= 1'b0;
         underrun_reg <= 1'b0;
         primed_reg   <= 1'b0;
      end else begin
         phase_reg <= phase_reg + PH_W'(1);
         if (take) begin
            x_reg      <= pcm_data;
            primed_reg <= 1'b1;
         end
         // set has priority over a coincident clear
         if (pcm_ready && !pcm_valid)
            underrun_reg <= 1'b1;
         else if (underrun_clr)
            underrun_reg <= 1'b0;
         // loop stays idle at zero until the first sample arrives after reset
         if (primed_reg) begin
            i1_reg  <= i1_next;
            i2_reg  <= i2_next;
            pdm_reg <= ~i2_next[ACC_W-1];
         end
      end
   end

   assign pdm_out  = pdm_reg;
   assign underrun = underrun_reg;

endmodule

// File: tb/tb_pdm_modulator.sv
// Self-checking bench for pdm_modulator: reference loop model feeds a scoreboard queue,
// plus density, underrun, reset and reproducibility checks.
module tb_pdm_modulator;

   localparam int PCM_W = 12;
   localparam int OSR   = 64;
   localparam int FS    = 2048;
   localparam int AMAX  = 32767;
   localparam int AMIN  = -32768;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b1;
   logic signed [PCM_W-1:0] pcm_data = '0;
   logic                    pcm_valid = 1'b1;
   logic                    pcm_ready;
   logic                    pdm_out;
   logic                    underrun;
   logic                    underrun_clr = 1'b0;

   always #5 clk = ~clk;

   pdm_modulator #(.PCM_W(PCM_W), .OSR(OSR)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pcm_data     (pcm_data),
      .pcm_valid    (pcm_valid),
      .pcm_ready    (pcm_ready),
      .pdm_out      (pdm_out),
      .underrun     (underrun),
      .underrun_clr (underrun_clr)
   );

   typedef struct packed {
      logic pdm;
      logic rdy;
      logic und;
   } exp_t;

   exp_t sb[$];

   int n_tests = 0;
   int n_fail  = 0;
   int ones;

   // reference model state
   int          m_phase, m_x, m_i1, m_i2;
   bit          m_out, m_und, m_run;
   logic [15:0] m_lfsr;

   bit r1[640];
   bit r2[640];

   task automatic check_eq(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v);
      if (v > AMAX) return AMAX;
      if (v < AMIN) return AMIN;
      return v;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_x = 0; m_i1 = 0; m_i2 = 0;
      m_out = 0; m_und = 0; m_run = 0;
      m_lfsr = 16'hACE1;
      sb.delete();
   endtask

   // advance model one edge using current inputs, push expectation, clock DUT, compare
   task automatic cycle();
      int   fb, xe, n1, n2;
      bit   rdy;
      exp_t e;
      logic [2:0] got;
      rdy = (m_phase == OSR - 1);
      fb  = m_out ? FS : -FS;
      xe  = m_x;
`ifdef PDM_DITHER_EN
      xe = m_x + (m_lfsr[0] ? 1 : -1);
`endif
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      if (m_run) begin
         n1 = sat(m_i1 + xe - fb);
         n2 = sat(m_i2 + m_i1 - fb);
         m_i1 = n1; m_i2 = n2; m_out = (n2 >= 0);
      end
      if (rdy && pcm_valid) begin
         m_x = int'(pcm_data);
         m_run = 1;
      end
      if (rdy && !pcm_valid) m_und = 1;
      else if (underrun_clr) m_und = 0;
      m_phase = (m_phase + 1) % OSR;
      sb.push_back('{pdm: m_out, rdy: (m_phase == OSR - 1), und: m_und});
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      got = {pdm_out, pcm_ready, underrun};
      check_eq("stream", int'(got), int'({e.pdm, e.rdy, e.und}));
      ones += int'(pdm_out);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!pcm_ready && n < OSR + 2) begin
         cycle();
         n++;
      end
      check_eq("wait_ready", int'(pcm_ready), 1);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_pdm", int'(pdm_out), 0);
      check_eq("rst_ready", int'(pcm_ready), 0);
      check_eq("rst_underrun", int'(underrun), 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // after reset: ready on cycle 64, output silent until then
   task automatic first_ready(input string tag);
      int cnt = 1;
      ones = 0;
      while (!pcm_ready && cnt < 200) begin
         cycle();
         cnt++;
      end
      check_eq(tag, cnt, 64);
      check_eq({tag, "_ones"}, ones, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int val, diffs, cnt;

      do_reset();
      first_ready("first_ready");
      $display("[TB] reset release: first pcm_ready observed");

      // x = 0 for 64 samples, density over last 2048 bits
      pcm_data = '0;
      run(2048);
      ones = 0;
      run(2048);
      val = (ones >= 1024 - 32 && ones <= 1024 + 32) ? 1024 : ones;
      check_eq("ones_zero", val, 1024);
      $display("[TB] x=0: %0d ones in 2048", ones);

      // near positive full scale
      pcm_data = 12'sd2047;
      run(128);
      ones = 0;
      run(4096);
      val = (ones >= 4064) ? 4064 : ones;
      check_eq("ones_pos", val, 4064);
      $display("[TB] x=+2047: %0d ones in 4096", ones);

      // negative full scale saturates, silence after settling
      pcm_data = -12'sd2048;
      run(256);
      ones = 0;
      run(1024);
      check_eq("ones_neg", ones, 0);
      $display("[TB] x=-2048: %0d ones in 1024", ones);

      // underrun set, hold, clear, set-wins
      pcm_data = 12'sd1000;
      wait_ready();
      cycle();
      wait_ready();
      pcm_valid = 1'b0;
      cycle();
      pcm_valid = 1'b1;
      check_eq("und_set", int'(underrun), 1);
      run(20);
      check_eq("und_sticky", int'(underrun), 1);
      underrun_clr = 1'b1;
      cycle();
      underrun_clr = 1'b0;
      check_eq("und_clr", int'(underrun), 0);
      wait_ready();
      pcm_valid = 1'b0;
      underrun_clr = 1'b1;
      cycle();
      pcm_valid = 1'b1;
      underrun_clr = 1'b0;
      check_eq("und_set_wins", int'(underrun), 1);
      $display("[TB] underrun sequence done");

      // reset mid-sample at phase 30 with x=1000 held
      wait_ready();
      cycle();
      run(30);
      do_reset();
      pcm_data = '0;
      first_ready("mid_rst_ready");
      $display("[TB] mid-sample reset recovered");

      // reproducibility after reset, and density near 50%
      do_reset();
      for (int k = 0; k < 640; k++) begin
         cycle();
         r1[k] = pdm_out;
      end
      do_reset();
      for (int k = 0; k < 640; k++) begin
         cycle();
         r2[k] = pdm_out;
      end
      diffs = 0;
      cnt = 0;
      for (int k = 0; k < 640; k++) begin
         if (r1[k] != r2[k]) diffs++;
         if (k >= 128 && r1[k]) cnt++;
      end
      check_eq("repeat_diff", diffs, 0);
      val = (cnt >= 256 - 10 && cnt <= 256 + 10) ? 256 : cnt;
      check_eq("density_half", val, 256);
      $display("[TB] reproducibility: %0d differing bits, %0d ones in 512", diffs, cnt);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pdm_modulator.md
PDM_MODULATOR -- requirements
Module: pdm_modulator

Interface
REQ-001 Parameter PCM_W, default 12: signed PCM sample width.
REQ-002 Parameter OSR, default 64: output bits per PCM sample, power of two, range 8..256.
REQ-003 clk  input  1  single clock; one PDM bit per rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 pcm_data  input  PCM_W  signed two's-complement sample.
REQ-006 pcm_valid  input  1  pcm_data valid this cycle.
REQ-007 pcm_ready  output  1  modulator accepts a sample this cycle.
REQ-008 pdm_out  output  1  registered 1-bit PDM stream.
REQ-009 underrun  output  1  sticky flag, a sample slot passed with no sample accepted.
REQ-010 underrun_clr  input  1  synchronous clear of underrun.

Function
REQ-011 The block SHALL contain a phase counter (log2 OSR bits) that increments every cycle and wraps from OSR-1 to 0.
REQ-012 pcm_ready SHALL be 1 only when the phase counter equals OSR-1; a sample transfers when pcm_valid and pcm_ready are both 1.
REQ-013 A transferred sample SHALL load the hold register x on that edge and be used for the following OSR cycles (zero-order-hold interpolation).
REQ-014 If pcm_ready=1 and pcm_valid=0, x SHALL keep its previous value and underrun SHALL set on that edge.
REQ-015 pcm_valid outside the ready cycle SHALL be ignored; the source holds data until transfer.
REQ-016 The accumulator width SHALL be ACC_W = PCM_W+4, and FS = 2^(PCM_W-1).
REQ-017 The feedback fb SHALL be +FS when pdm_out=1 and -FS when pdm_out=0.
REQ-018 Every cycle, i1 <= sat(i1 + x - fb) and i2 <= sat(i2 + i1_old - fb), where sat clamps to the ACC_W signed range.
REQ-019 pdm_out SHALL be registered as (i2_new >= 0), so the first effect of a new sample appears on pdm_out two edges after transfer.
REQ-020 Long-run ones density SHALL be (x+FS)/(2*FS) to within 1/OSR over any 16*OSR window.
REQ-021 If underrun_clr and a new underrun occur on the same edge, underrun SHALL remain 1 (set wins).
REQ-022 An input of -FS SHALL saturate the accumulators without wrapping and SHALL produce all-zero output after settling.

Reset
REQ-023 While rst_n=0, the block SHALL force phase=0, x=0, i1=0, i2=0, pdm_out=0, underrun=0 and pcm_ready=0, asynchronously.
REQ-024 The first pcm_ready pulse after rst_n rises SHALL occur OSR cycles after the first clock edge, not earlier.
REQ-025 Reset asserted mid-sample SHALL discard the held sample and the accumulator state, with no partial-window output afterwards.

Configuration
REQ-026 Macro PDM_DITHER_EN SHALL control dither, and only dither.
- Defined: a 16-bit maximal LFSR (seed 16'hACE1, reset-loaded) adds +1 or -1 LSB to x each cycle, selected by LFSR bit 0.
- Undefined: no LFSR is instantiated and the output is fully deterministic.

Structure
REQ-027 Package pdm_pkg SHALL hold PCM_W, OSR, ACC_W, FS, the saturation limits, and the LFSR seed and taps.
REQ-028 Sub-module pdm_lfsr (enable, state, bit output) SHALL exist and be instantiated only under PDM_DITHER_EN.

Verification
REQ-029 Reset release -> pdm_out=0 and pcm_ready=0 for 63 cycles, then pcm_ready=1 on cycle 64 (OSR=64).
REQ-030 Constant x=0 for 64 samples -> ones count in the last 2048 bits = 1024±32.
REQ-031 Constant x=+2047 -> ones count in 4096 bits >= 4064; constant x=-2048 -> 0 ones after the first 128 bits, and i1 and i2 never wrap.
REQ-032 pcm_valid withheld for one slot -> underrun=1 and x unchanged; underrun_clr pulsed -> 0; simultaneous clear and underrun -> stays 1.
REQ-033 rst_n pulsed low at phase 30 while x=1000 -> all state zero, next pcm_ready 64 cycles after release.
REQ-034 With PDM_DITHER_EN, x=0 -> density 50%±2% and bitstream differs from the non-dither run; seed reproducible after each reset.
